// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: operation encodings ({funct7[5], funct3})
// and the two-state sequencer enum.
package alu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b1000,
        OP_SLL  = 4'b0001,
        OP_SLT  = 4'b0010,
        OP_SLTU = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_SRL  = 4'b0101,
        OP_SRA  = 4'b1101,
        OP_OR   = 4'b0110,
        OP_AND  = 4'b0111
    } aluOp_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic logic is_shift(aluOp_t op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Combinational single-step shifter: moves value by 0..STEP bits left or right,
// with sign fill on arithmetic right shifts.
module alu_shift_step
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    parameter int AW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] value,
    input  logic [AW-1:0]    amount,
    input  logic             left,
    input  logic             arith,
    output logic [WIDTH-1:0] shifted
);

    always_comb begin
        if (left) begin
            shifted = value << amount;
        end else if (arith) begin
            shifted = WIDTH'($signed(value) >>> amount);
        end else begin
            shifted = value >> amount;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith/compare, iterative shifts SHIFT_STEP bits
// per cycle, start/busy/done handshake. Define ALU_FLAGS_EN for aluZero/aluNeg outputs.
module alu_seq
    import alu_pkg::*;
#(
    parameter int XLEN       = alu_pkg::XLEN,
    parameter int SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] aluA,
    input  logic [XLEN-1:0] aluB,
    input  logic [3:0]      aluOp,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] aluRes
`ifdef ALU_FLAGS_EN
    ,
    output logic            aluZero,
    output logic            aluNeg
`endif
);

    localparam int AW = $clog2(SHIFT_STEP + 1);

    state_t          state;
    logic [4:0]      cnt;
    logic [XLEN-1:0] work;
    logic            shift_left;
    logic            shift_arith;

    aluOp_t          op;
    logic [4:0]      shamt;
    logic            accept;
    logic            go_shift;
    logic            finish;
    logic [AW-1:0]   step_amt;
    logic [XLEN-1:0] step_out;
    logic [XLEN-1:0] res_next;

    function automatic logic [XLEN-1:0] alu_single(aluOp_t f_op, logic [XLEN-1:0] a,
                                                   logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
        r = '0;
        case (f_op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_SLT:  r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
            OP_XOR:  r = a ^ b;
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
            // Only reached with shamt == 0, which is a pass-through.
            OP_SLL, OP_SRL, OP_SRA: r = a;
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        op       = aluOp_t'(aluOp);
        shamt    = aluB[4:0];
        accept   = (state == IDLE) && start;
        go_shift = is_shift(op) && (shamt != 5'd0);
        step_amt = (cnt > 5'(SHIFT_STEP)) ? AW'(SHIFT_STEP) : AW'(cnt);
        finish   = (accept && !go_shift) || ((state == SHIFT) && (cnt <= 5'(SHIFT_STEP)));
        res_next = (state == SHIFT) ? step_out : alu_single(op, aluA, aluB);
    end

    alu_shift_step #(
        .WIDTH (XLEN),
        .STEP  (SHIFT_STEP)
    ) u_shift_step (
        .value   (work),
        .amount  (step_amt),
        .left    (shift_left),
        .arith   (shift_arith),
        .shifted (step_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            aluRes <= '0;
            cnt    <= 5'd0;
        end else begin
            done <= finish;
            if (finish) begin
                aluRes <= res_next;
            end
            if (state == IDLE) begin
                if (accept && go_shift) begin
                    state <= SHIFT;
                    busy  <= 1'b1;
                    cnt   <= shamt;
                end
            end else begin
                cnt <= cnt - 5'(step_amt);
                if (finish) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end
        end
    end

    // Shift datapath: loaded at accept, stepped every SHIFT cycle; no reset needed.
    always_ff @(posedge clk) begin
        if (accept && go_shift) begin
            work        <= aluA;
            shift_left  <= (op == OP_SLL);
            shift_arith <= (op == OP_SRA);
        end else if (state == SHIFT) begin
            work <= step_out;
        end
    end

`ifdef ALU_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            aluZero <= 1'b1;
            aluNeg  <= 1'b0;
        end else if (finish) begin
            aluZero <= (res_next == '0);
            aluNeg  <= res_next[XLEN-1];
        end
    end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases plus random ops against a
// plain-arithmetic reference model.
module tb_alu_seq;

    localparam int XLEN = 32;
    localparam int STEP = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [XLEN-1:0] aluA;
    logic [XLEN-1:0] aluB;
    logic [3:0]      aluOp;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] aluRes;
`ifdef ALU_FLAGS_EN
    logic            aluZero;
    logic            aluNeg;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq #(
        .XLEN       (XLEN),
        .SHIFT_STEP (STEP)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .aluA   (aluA),
        .aluB   (aluB),
        .aluOp  (aluOp),
        .busy   (busy),
        .done   (done),
        .aluRes (aluRes)
`ifdef ALU_FLAGS_EN
        ,
        .aluZero(aluZero),
        .aluNeg (aluNeg)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic [XLEN-1:0] exp);
`ifdef ALU_FLAGS_EN
        check({tag, "_zero"}, {31'd0, aluZero}, {31'd0, (exp == 0)});
        check({tag, "_neg"},  {31'd0, aluNeg},  {31'd0, exp[XLEN-1]});
`else
        if (tag.len() == 0) $display("empty tag for %h", exp);
`endif
    endtask

    // Reference: the whole result in one arithmetic step, latency in edges after accept.
    task automatic model(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         output logic [XLEN-1:0] res, output int lat);
        int sh;
        sh  = int'(b[4:0]);
        lat = 0;
        case (op)
            4'b0000: res = a + b;
            4'b1000: res = a - b;
            4'b0010: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: res = (a < b) ? 32'd1 : 32'd0;
            4'b0100: res = a ^ b;
            4'b0110: res = a | b;
            4'b0111: res = a & b;
            4'b0001: begin res = a << sh; lat = (sh + STEP - 1) / STEP; end
            4'b0101: begin res = a >> sh; lat = (sh + STEP - 1) / STEP; end
            4'b1101: begin res = $signed(a) >>> sh; lat = (sh + STEP - 1) / STEP; end
            default: res = 32'd0;
        endcase
    endtask

    // Entered and left at #1 after a rising edge with the DUT idle.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input bit hold);
        logic [XLEN-1:0] exp;
        int elat, lat, nbusy;
        model(op, a, b, exp, elat);
        aluOp = op; aluA = a; aluB = b; start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        aluA = $urandom; aluB = $urandom;
        if (!hold) aluOp = 4'($urandom);
        lat = 0; nbusy = 0;
        while (!done && lat < 200) begin
            nbusy += int'(busy);
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check({tag, "_latency"}, lat, elat);
        check({tag, "_busy_cycles"}, nbusy, elat);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        check({tag, "_result"}, aluRes, exp);
        check_flags(tag, exp);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_hold"}, aluRes, exp);
    endtask

    initial begin
        logic [3:0] ops [12];
        int n_done;
        ops = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                4'b0101, 4'b1101, 4'b0110, 4'b0111, 4'b1111, 4'b1010};
        rst = 1'b1; start = 1'b0; aluA = '0; aluB = '0; aluOp = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_res", aluRes, 32'd0);
        check_flags("reset", 32'd0);

        run_op("add_ovf", 4'b0000, 32'h7FFF_FFFF, 32'd1, 1'b0);
        run_op("sub_zero", 4'b1000, 32'd5, 32'd5, 1'b0);
        run_op("slt", 4'b0010, 32'hFFFF_FFFF, 32'd1, 1'b0);
        run_op("sltu", 4'b0011, 32'hFFFF_FFFF, 32'd1, 1'b0);
        run_op("undef", 4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        run_op("sra4", 4'b1101, 32'h8000_0000, 32'd4, 1'b0);
        run_op("sll0", 4'b0001, 32'hDEAD_BEEF, 32'd0, 1'b0);
        run_op("srl31_hold", 4'b0101, 32'h8000_0000, 32'd31, 1'b1);
        repeat (3) begin
            @(posedge clk); #1;
            check("hold_no_second_done", {31'd0, done}, 32'd0);
        end

        // Back-to-back: a new ADD presented in the done cycle.
        aluOp = 4'b0000; aluA = 32'd10; aluB = 32'd20; start = 1'b1;
        @(posedge clk); #1;
        check("b2b_done1", {31'd0, done}, 32'd1);
        check("b2b_res1", aluRes, 32'd30);
        aluA = 32'd100; aluB = 32'd1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_done2", {31'd0, done}, 32'd1);
        check("b2b_res2", aluRes, 32'd101);
        @(posedge clk); #1;
        check("b2b_done_low", {31'd0, done}, 32'd0);

        // Reset in the 5th busy cycle of SLL by 20.
        aluOp = 4'b0001; aluA = 32'd1; aluB = 32'd20; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("rstmid_busy1", {31'd0, busy}, 32'd1);
        repeat (4) begin @(posedge clk); #1; end
        check("rstmid_busy5", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check("rstmid_done", {31'd0, done}, 32'd0);
        check("rstmid_res", aluRes, 32'd0);
        n_done = 0;
        repeat (25) begin
            @(posedge clk); #1;
            n_done += int'(done);
        end
        check("rstmid_no_done", n_done, 0);
        run_op("add_after_rst", 4'b0000, 32'd2, 32'd3, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_op("rand", ops[$urandom_range(0, 11)], $urandom, $urandom, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
